// File: rtl/quad_decoder.sv
// Quadrature front end: synchronizes and glitch-filters A/B, then turns Gray-phase steps into Up/Down/Err pulses.
// Optional QD_ERR_CNT_EN adds Clr_Err and a saturating 8-bit Err_Cnt.
module quad_decoder #(
    parameter int FILT_LEN = 3,
    parameter int DEC_MODE = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       A,
    input  logic       B,
`ifdef QD_ERR_CNT_EN
    input  logic       Clr_Err,
    output logic [7:0] Err_Cnt,
`endif
    output logic       Up,
    output logic       Down,
    output logic       Dir,
    output logic       Err,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S10 = 2'b10,
        S11 = 2'b11
    } phase_t;

    localparam logic [3:0] CNT_LAST = 4'(FILT_LEN - 1);
    localparam bit         FULL_RES = (DEC_MODE != 1);

    // Bit 1 carries channel A, bit 0 carries channel B throughout.
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      filt;
    logic [1:0][3:0] filt_cnt;

    phase_t state;
    phase_t fwd_next;
    phase_t rev_next;
    logic   step_fwd;
    logic   step_rev;
    logic   step_ill;
    logic   up_hit;
    logic   down_hit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= {A, B};
            sync2 <= sync1;
        end
    end

    // A channel only moves after FILT_LEN consecutive samples disagree with it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            filt     <= 2'b00;
            filt_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    filt_cnt[i] <= 4'd0;
                end else if (filt_cnt[i] == CNT_LAST) begin
                    filt[i]     <= sync2[i];
                    filt_cnt[i] <= 4'd0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        fwd_next = S10;
        rev_next = S01;
        case (state)
            S00: begin fwd_next = S10; rev_next = S01; end
            S10: begin fwd_next = S11; rev_next = S00; end
            S11: begin fwd_next = S01; rev_next = S10; end
            S01: begin fwd_next = S00; rev_next = S11; end
            default: begin fwd_next = S10; rev_next = S01; end
        endcase
        step_fwd = (filt == fwd_next);
        step_rev = (filt == rev_next);
        step_ill = ((filt ^ state) == 2'b11);
        // Single resolution only reports the S00<->S10 edge of each cycle.
        up_hit   = step_fwd && (FULL_RES || state == S00);
        down_hit = step_rev && (FULL_RES || state == S10);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S00;
            Up    <= 1'b0;
            Down  <= 1'b0;
            Err   <= 1'b0;
            Dir   <= 1'b0;
        end else begin
            state <= phase_t'(filt);
            Up    <= EN && up_hit;
            Down  <= EN && down_hit;
            Err   <= EN && step_ill;
            if (step_fwd) begin
                Dir <= 1'b1;
            end else if (step_rev) begin
                Dir <= 1'b0;
            end
        end
    end

`ifdef QD_ERR_CNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Err_Cnt <= 8'd0;
        end else if (Clr_Err) begin
            Err_Cnt <= 8'd0;
        end else if (EN && step_ill && Err_Cnt != 8'hFF) begin
            Err_Cnt <= Err_Cnt + 8'd1;
        end
    end
`endif

    assign dbg_state = state;

endmodule
